// File: rtl/wb_sequencer_pkg.sv
// Shared types for the write-back path: register address width, x0 and the
// buffered long-unit result entry.
package wb_sequencer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_XLEN    = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO of write-back entries; head is visible combinationally
// so the consumer can write it and pop it on the same edge.
module wb_fifo
  import wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/wb_sequencer.sv
// Drives the single register-file write port from the ALU (priority) and a
// FIFO of long-latency results, tracking pending registers for issue hazards.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int NREG  = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_data,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       wreg,
  output logic                  we,
  output logic [NREG-1:0]       busy_vec,
  output logic                  err
);

  logic            fifo_full;
  logic            fifo_empty;
  wb_entry_t       fifo_head;
  wb_entry_t       fifo_din;
  logic            push;
  logic            pop;
  logic            set_busy;
  logic            viol;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            err_q;

  // lu_ready depends only on registered FIFO state, never on this cycle's ALU.
  assign lu_ready = !reset && !fifo_full;
  assign push     = lu_valid && lu_ready && (lu_rd != X0);
  assign pop      = !reset && !alu_valid && !fifo_empty;
  assign fifo_din = '{rd: lu_rd, data: lu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_addr = X0;
    wreg    = '0;
    we      = 1'b0;
    if (!reset) begin
      if (alu_valid) begin
        rd_addr = alu_rd;
        wreg    = alu_data;
        we      = (alu_rd != X0);
      end else if (!fifo_empty) begin
        rd_addr = fifo_head.rd;
        wreg    = fifo_head.data;
        we      = 1'b1;
      end
    end
  end

  // No bypass: a register popped this cycle still stalls dependents.
  assign hazard = !reset &&
                  (busy[rs1_addr] || busy[rs2_addr] || (iss_valid && busy[iss_rd]));

  assign set_busy = iss_valid && iss_long && !hazard && (iss_rd != X0);

  always_comb begin
    busy_nxt = busy;
    if (pop)      busy_nxt[fifo_head.rd] = 1'b0;
    if (set_busy) busy_nxt[iss_rd]       = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign viol = (alu_valid && (alu_rd != X0) && busy[alu_rd]) ||
                (push && !busy[lu_rd]);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (viol) err_q <= 1'b1;
    end
  end

  assign busy_vec = busy;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the write-back rules.
module tb_wb_sequencer;
  import wb_sequencer_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            iss_valid, iss_long;
  logic [4:0]      iss_rd, rs1_addr, rs2_addr;
  logic            hazard;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lu_valid, lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] wreg;
  logic            we;
  logic [NREG-1:0] busy_vec;
  logic            err;

  always #5 clk = ~clk;

  wb_sequencer #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rd_addr(rd_addr), .wreg(wreg), .we(we), .busy_vec(busy_vec), .err(err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  bit   busy_m[NREG];
  bit   err_m = 1'b0;

  logic [4:0]  e_rd;
  logic [31:0] e_wreg;
  logic        e_we, e_ready, e_haz;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] busy_bits();
    logic [NREG-1:0] v = '0;
    for (int i = 0; i < NREG; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic idle();
    iss_valid = 0; iss_long = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  // Compare outputs against the model mid-cycle, inputs held stable.
  task automatic settle();
    @(negedge clk);
    e_we = 0; e_rd = 0; e_wreg = 0; e_ready = 0; e_haz = 0;
    if (!reset) begin
      if (alu_valid) begin
        e_we = (alu_rd != 0); e_rd = alu_rd; e_wreg = alu_data;
      end else if (q.size() > 0) begin
        e_we = 1; e_rd = q[0].rd; e_wreg = q[0].data;
      end
      e_ready = (q.size() < DEPTH);
      e_haz   = busy_m[rs1_addr] | busy_m[rs2_addr] | (iss_valid & busy_m[iss_rd]);
    end
    check("we",       64'(we),       64'(e_we));
    check("rd_addr",  64'(rd_addr),  64'(e_rd));
    check("wreg",     64'(wreg),     64'(e_wreg));
    check("lu_ready", 64'(lu_ready), 64'(e_ready));
    check("hazard",   64'(hazard),   64'(e_haz));
    check("busy_vec", 64'(busy_vec), 64'(busy_bits()));
    check("err",      64'(err),      64'(err_m));
  endtask

  // Apply the clock-edge rules to the model, then advance past the edge.
  task automatic adv();
    bit popped, acc;
    if (reset) begin
      q.delete();
      for (int i = 0; i < NREG; i++) busy_m[i] = 0;
      err_m = 0;
    end else begin
      popped = !alu_valid && (q.size() > 0);
      acc    = lu_valid && e_ready;
      if (alu_valid && alu_rd != 0 && busy_m[alu_rd]) err_m = 1;
      if (acc && lu_rd != 0 && !busy_m[lu_rd])        err_m = 1;
      if (popped) begin
        busy_m[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (acc && lu_rd != 0) q.push_back('{rd: lu_rd, data: lu_data});
      if (iss_valid && iss_long && !e_haz && iss_rd != 0) busy_m[iss_rd] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle(); iss_valid = 1; iss_long = 1; iss_rd = rd;
    tick();
    idle();
  endtask

  initial begin
    reset = 1; idle();
    tick(); tick();
    reset = 0;
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    settle();
    check("alu_we_const",   64'(we), 64'd1);
    check("alu_wreg_const", 64'(wreg), 64'hDEADBEEF);
    adv();
    alu_rd = 0;
    settle();
    check("alu_x0_we", 64'(we), 64'd0);
    adv();
    idle();

    // Long path
    issue_long(7);
    rs1_addr = 7;
    settle();
    check("lp_busy7",  64'(busy_vec[7]), 64'd1);
    check("lp_hazard", 64'(hazard), 64'd1);
    adv();
    lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
    tick();
    lu_valid = 0;
    settle();
    check("lp_wr_rd",   64'(rd_addr), 64'd7);
    check("lp_wr_data", 64'(wreg), 64'h1234);
    adv();
    settle();
    check("lp_hazard_drop", 64'(hazard), 64'd0);
    adv();
    idle();

    // Contention: ALU holds off the buffered rd=3 for four cycles
    issue_long(3);
    lu_valid = 1; lu_rd = 3; lu_data = 32'hC0FFEE03;
    tick();
    lu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'h100 + i;
      settle();
      check("ct_busy3_held", 64'(busy_vec[3]), 64'd1);
      adv();
    end
    idle();
    settle();
    check("ct_drain_rd", 64'(rd_addr), 64'd3);
    adv();
    tick();

    // Backpressure with the ALU busy, then drain in order
    issue_long(3); issue_long(4); issue_long(5);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h55;
    lu_valid = 1; lu_rd = 3; lu_data = 32'hA3;
    tick();
    lu_rd = 4; lu_data = 32'hA4;
    tick();
    lu_rd = 5; lu_data = 32'hA5;
    settle();
    check("bp_full_ready", 64'(lu_ready), 64'd0);
    adv();
    alu_valid = 0;
    settle();
    check("bp_drain0", 64'(rd_addr), 64'd3);
    adv();
    settle();
    check("bp_drain1", 64'(rd_addr), 64'd4);
    check("bp_ready_back", 64'(lu_ready), 64'd1);
    adv();
    lu_valid = 0;
    settle();
    check("bp_drain2", 64'(rd_addr), 64'd5);
    adv();
    settle();
    check("bp_busy_clear", 64'(busy_vec), 64'd0);
    adv();

    // Violations
    issue_long(9);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    tick();
    idle();
    tick(); tick();
    settle();
    check("viol_alu_sticky", 64'(err), 64'd1);
    adv();
    reset = 1; tick(); reset = 0;
    lu_valid = 1; lu_rd = 10; lu_data = 32'hA;
    tick();
    idle();
    settle();
    check("viol_lu_err", 64'(err), 64'd1);
    adv();

    // Reset mid-drain
    reset = 1; tick(); reset = 0;
    issue_long(11); issue_long(12);
    alu_valid = 1; alu_rd = 11; alu_data = 32'hB;
    lu_valid = 1; lu_rd = 11; lu_data = 32'h11;
    tick();
    lu_rd = 12; lu_data = 32'h12;
    tick();
    reset = 1; alu_valid = 0;
    tick();
    reset = 0; idle();
    settle();
    check("rst_busy",  64'(busy_vec), 64'd0);
    check("rst_we",    64'(we), 64'd0);
    check("rst_ready", 64'(lu_ready), 64'd1);
    check("rst_err",   64'(err), 64'd0);
    adv();

    // Randomized traffic with periodic resets
    for (int n = 0; n < 400; n++) begin
      int k;
      reset     = (n % 50 == 49);
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = ($urandom_range(0, 3) != 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 7));
      if (busy_m[alu_rd] && $urandom_range(0, 3) != 0) alu_rd = 0;
      alu_data  = $urandom;
      lu_valid  = 1'($urandom_range(0, 1));
      k         = $urandom_range(0, 7);
      lu_rd     = 5'(k);
      for (int j = 0; j < 8; j++) begin
        if (busy_m[(k + j) % 8]) begin
          lu_rd = 5'((k + j) % 8);
          break;
        end
      end
      lu_data   = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
